// File: rtl/mrr_loopback_pop_arbiter.sv
// Round-robin arbiter sharing the loopback queue pop port among NUM_REQ decode pathways.
// Optional WAIT timeout with a saturating timeout_count port: define MRR_LB_ARB_TIMEOUT_EN.
module mrr_loopback_pop_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_IDX_WIDTH  = 2,
  parameter int CHIP_ID_LEN    = 16,
  parameter int MSG_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*CHIP_ID_LEN-1:0] req_chip_id,
  input  logic [NUM_REQ-1:0]             req_request,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [MSG_LEN-1:0]             req_message,
  output logic [CHIP_ID_LEN-1:0]         q_chip_id,
  output logic                           q_request,
  input  logic                           q_ack,
  input  logic [MSG_LEN-1:0]             q_message,
  output logic [REQ_IDX_WIDTH-1:0]       grant_idx,
  output logic                           busy
`ifdef MRR_LB_ARB_TIMEOUT_EN
  ,
  output logic [15:0]                    timeout_count
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND, GAP} state_t;

  state_t                   state;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr;
  logic                     abort;

  logic                     found;
  logic [REQ_IDX_WIDTH-1:0] pick;
  logic [CHIP_ID_LEN-1:0]   pick_chip;
  int                       idx;

  // Descending scan so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_chip = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_request[idx]) begin
        found     = 1'b1;
        pick      = REQ_IDX_WIDTH'(idx);
        pick_chip = req_chip_id[CHIP_ID_LEN*idx +: CHIP_ID_LEN];
      end
    end
  end

  logic               abort_now;
  logic               timed_out;
  logic [NUM_REQ-1:0] grant_onehot;

  // A request drop in the ack cycle itself still counts as an abort.
  assign abort_now    = abort | ~req_request[grant_idx];
  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;

`ifdef MRR_LB_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wait_cnt;

  assign timed_out = (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) && !q_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt      <= '0;
      timeout_count <= '0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (state == WAIT && timed_out && timeout_count != 16'hFFFF)
        timeout_count <= timeout_count + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      abort       <= 1'b0;
      req_ack     <= '0;
      req_message <= '0;
      q_chip_id   <= '0;
      q_request   <= 1'b0;
      grant_idx   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx <= pick;
            q_chip_id <= pick_chip;
            q_request <= 1'b1;
            busy      <= 1'b1;
            abort     <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          abort <= abort_now | timed_out;
          if (q_ack || timed_out) begin
            q_request <= 1'b0;
            state     <= RESPOND;
            if (q_ack && !abort_now) begin
              req_message <= q_message;
              req_ack     <= grant_onehot;
            end
          end
        end
        RESPOND: begin
          req_ack <= '0;
          abort   <= 1'b0;
          rr_ptr  <= (grant_idx == REQ_IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state   <= GAP;
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mrr_loopback_pop_arbiter.sv
// Directed bench for mrr_loopback_pop_arbiter with a transaction-level reference model.
module tb_mrr_loopback_pop_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 16;
  localparam int MW = 64;
  localparam int TO = 8;
`ifdef MRR_LB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N*CW-1:0] req_chip_id = '0;
  logic [N-1:0]  req_request = '0;
  logic [N-1:0]  req_ack;
  logic [MW-1:0] req_message;
  logic [CW-1:0] q_chip_id;
  logic          q_request;
  logic          q_ack = 1'b0;
  logic [MW-1:0] q_message = '0;
  logic [IW-1:0] grant_idx;
  logic          busy;
`ifdef MRR_LB_ARB_TIMEOUT_EN
  logic [15:0]   timeout_count;
`endif

  always #5 clk = ~clk;

  mrr_loopback_pop_arbiter #(
    .NUM_REQ(N), .REQ_IDX_WIDTH(IW), .CHIP_ID_LEN(CW), .MSG_LEN(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_chip_id(req_chip_id), .req_request(req_request),
    .req_ack(req_ack), .req_message(req_message), .q_chip_id(q_chip_id),
    .q_request(q_request), .q_ack(q_ack), .q_message(q_message),
    .grant_idx(grant_idx), .busy(busy)
`ifdef MRR_LB_ARB_TIMEOUT_EN
    , .timeout_count(timeout_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, then a two-cycle quiet period.
  bit            m_infl = 0, m_abort = 0;
  int            m_g = 0, m_rr = 0, m_hold = 0, m_wait = 0;
  logic [N-1:0]  m_ack = '0;
  logic [MW-1:0] m_msg = '0;
  logic [CW-1:0] m_chip = '0;
  logic          m_qreq = 0, m_busy = 0;
  logic [15:0]   m_tocnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_infl = 0; m_abort = 0; m_g = 0; m_rr = 0; m_hold = 0; m_wait = 0;
      m_ack = '0; m_msg = '0; m_chip = '0; m_qreq = 0; m_busy = 0; m_tocnt = '0;
    end else begin
      m_ack = '0;
      if (m_infl) begin
        if (!req_request[m_g]) m_abort = 1;
        m_wait++;
        if (q_ack || (TO_EN && m_wait == TO)) begin
          if (!q_ack) begin
            m_abort = 1;
            if (m_tocnt != 16'hFFFF) m_tocnt++;
          end
          if (!m_abort) begin
            m_ack[m_g] = 1'b1;
            m_msg = q_message;
          end
          m_infl = 0; m_qreq = 0;
          m_rr = (m_g + 1) % N;
          m_hold = 2;
        end
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_busy = 0;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!m_infl && req_request[(m_rr + k) % N]) begin
            m_g = (m_rr + k) % N;
            m_infl = 1; m_abort = 0; m_wait = 0;
            m_chip = req_chip_id[CW*m_g +: CW];
            m_qreq = 1; m_busy = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ack", 64'(req_ack), 64'(m_ack));
      chk("req_message", req_message, m_msg);
      chk("q_chip_id", 64'(q_chip_id), 64'(m_chip));
      chk("q_request", 64'(q_request), 64'(m_qreq));
      chk("grant_idx", 64'(grant_idx), 64'(m_g));
      chk("busy", 64'(busy), 64'(m_busy));
`ifdef MRR_LB_ARB_TIMEOUT_EN
      chk("timeout_count", 64'(timeout_count), 64'(m_tocnt));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_qreq();
    int n = 0;
    while (!q_request && n < 200) begin
      tick();
      n++;
    end
    chk("wait_q_request", 64'(q_request), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("wait_idle", 64'(busy), 64'd0);
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < N; i++) req_chip_id[CW*i +: CW] = 16'h0100 + 16'(i);
    req_chip_id[CW*2 +: CW] = 16'h00A5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    chk("rst_req_message", req_message, 64'd0);
    chk("rst_q_request", 64'(q_request), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // Single request from pathway 2, queue answers three cycles later.
    req_request = 4'b0100;
    wait_qreq();
    chk("single_chip", 64'(q_chip_id), 64'h00A5);
    chk("single_grant", 64'(grant_idx), 64'd2);
    repeat (3) tick();
    q_ack = 1'b1; q_message = 64'h1234;
    tick();
    q_ack = 1'b0; q_message = 64'hDEAD_BEEF;
    chk("single_ack", 64'(req_ack), 64'h4);
    chk("single_msg", req_message, 64'h1234);
    req_request = '0;
    tick();
    chk("single_ack_pulse", 64'(req_ack), 64'd0);
    wait_idle();

    // Abort: pathway 1 withdraws while the queue is still working.
    req_request = 4'b0010;
    wait_qreq();
    chk("abort_grant", 64'(grant_idx), 64'd1);
    tick();
    req_request = '0;
    repeat (4) begin
      tick();
      chk("abort_q_held", 64'(q_request), 64'd1);
    end
    q_ack = 1'b1; q_message = 64'h5555;
    tick();
    q_ack = 1'b0;
    chk("abort_no_ack", 64'(req_ack), 64'd0);
    chk("abort_msg_kept", req_message, 64'h1234);
    wait_idle();

    // Search must resume at index 2, so 3 wins over 0 and 1; then race the drop with q_ack.
    req_request = 4'b1011;
    wait_qreq();
    chk("resume_grant", 64'(grant_idx), 64'd3);
    repeat (2) tick();
    q_ack = 1'b1; q_message = 64'h7777; req_request = 4'b0011;
    tick();
    q_ack = 1'b0;
    chk("race_no_ack", 64'(req_ack), 64'd0);
    chk("race_msg_kept", req_message, 64'h1234);
    req_request = '0;
    wait_idle();

    // Asynchronous reset while waiting on the queue.
    req_request = 4'b0110;
    wait_qreq();
    chk("prereset_grant", 64'(grant_idx), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_q_request", 64'(q_request), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_grant", 64'(grant_idx), 64'd0);
    req_request = '0;
    tick();
    rst = 1'b0;
    tick();

    // All requesters active: grants rotate from 0.
    req_request = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_qreq();
      chk("rr_grant", 64'(grant_idx), 64'(rr_exp[i]));
      q_ack = 1'b1; q_message = 64'h100 + 64'(i);
      tick();
      q_ack = 1'b0;
      chk("rr_ack", 64'(req_ack), 64'(1 << rr_exp[i]));
    end
    req_request = '0;
    wait_idle();

`ifdef MRR_LB_ARB_TIMEOUT_EN
    // Queue never answers: request must fall after TO wait cycles, then pathway 2 is served.
    req_request = 4'b0110;
    wait_qreq();
    chk("to_grant", 64'(grant_idx), 64'd1);
    begin
      int n = 0;
      while (q_request && n < 50) begin
        tick();
        n++;
      end
      chk("to_wait_cycles", 64'(n), 64'(TO));
    end
    chk("to_no_ack", 64'(req_ack), 64'd0);
    chk("to_count", 64'(timeout_count), 64'd1);
    wait_qreq();
    chk("to_next_grant", 64'(grant_idx), 64'd2);
    q_ack = 1'b1; q_message = 64'h9999;
    tick();
    q_ack = 1'b0;
    chk("to_next_ack", 64'(req_ack), 64'h4);
    req_request = '0;
    wait_idle();
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mrr_loopback_pop_arbiter.md
Name: mrr_loopback_pop_arbiter

Overview:
- Shares the single pop port of the per-node loopback queue among NUM_REQ decode pathways.
- Each pathway raises a pop request carrying a chip ID. The arbiter grants one requester at a time, round-robin, and forwards the request to the queue.
- It returns the queue's message and ack to the granted pathway only.
- It sits between the per-pathway loopback/decode blocks and the loopback queue.

Parameters:
- NUM_REQ, 4, number of requesting pathways (2..16, power of two not required)
- REQ_IDX_WIDTH, 2, width of grant index; must be at least clog2(NUM_REQ)
- CHIP_ID_LEN, 16, chip ID width
- MSG_LEN, 64, loopback message width
- TIMEOUT_CYCLES, 1023, queue-ack timeout (used only with optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req_chip_id  in  NUM_REQ*CHIP_ID_LEN  per-requester chip ID; requester i in slice [CHIP_ID_LEN*(i+1)-1 -: CHIP_ID_LEN]
- req_request  in  NUM_REQ  level request; held high until ack or abort
- req_ack  out  NUM_REQ  one-cycle ack pulse to the granted requester
- req_message  out  MSG_LEN  shared response message; valid in the req_ack cycle, held until the next response
- q_chip_id  out  CHIP_ID_LEN  chip ID presented to the queue
- q_request  out  1  request to the queue
- q_ack  in  1  one-cycle queue ack; q_message valid in the same cycle
- q_message  in  MSG_LEN  queue response
- grant_idx  out  REQ_IDX_WIDTH  current or last granted requester
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - req_ack=0, req_message=0, q_chip_id=0, q_request=0, grant_idx=0, busy=0
  - rr_ptr=0, state=IDLE, abort flag=0
- All outputs are registered.
- State IDLE:
  - Pick the first i with req_request[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - If one is found: latch grant_idx=i, q_chip_id=req_chip_id[i], set q_request=1, go to WAIT. q_request is high the cycle after the request is sampled.
  - If none is found: stay in IDLE.
- State WAIT:
  - q_chip_id and q_request are held stable.
  - On q_ack=1: clear q_request, latch req_message=q_message, go to RESPOND.
  - If req_request[grant_idx] drops while in WAIT, set the abort flag. q_request stays high until q_ack; the queue is never left half-handshaken.
- State RESPOND (1 cycle):
  - If abort=0: req_ack[grant_idx]=1 for exactly this cycle.
  - If abort=1: no ack, and req_message is not updated (it keeps its previous value).
  - rr_ptr = grant_idx+1, wrapping to 0 when equal to NUM_REQ. Clear abort. Go to GAP.
- State GAP (1 cycle): no sampling. This gives the requester a cycle to drop its request. Go to IDLE.
- Latency:
  - q_ack at cycle M gives req_ack at M+1.
  - The earliest next q_request is at M+4 (RESPOND at M+1, GAP at M+2, IDLE sample at M+3).
- Fairness: with all requesters continuously active, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Simultaneous events:
  - q_ack in the same cycle as the request drops: the abort flag is set that cycle; no ack is issued.
  - q_ack outside WAIT is ignored.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); an in-flight queue transaction is abandoned.
- Only req_ack[grant_idx] can ever be asserted; req_ack is one-hot or zero.

Optional Feature:
- Macro: MRR_LB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT, reset on entry.
  - If it reaches TIMEOUT_CYCLES without q_ack: drop q_request and go to RESPOND with abort forced to 1, so no ack is issued and rr_ptr still advances.
  - Extra output timeout_count (out, 16 bits) increments per timeout, saturates at 0xFFFF, and resets to 0.
- Without the macro: WAIT waits indefinitely, there is no counter, and the timeout_count port does not exist.

Test Plan:
- Single request: req_request=4'b0100, chip_id[2]=16'h00A5; queue acks 3 cycles later with q_message=64'h1234 → q_chip_id=16'h00A5; req_ack=4'b0100 for exactly 1 cycle, one cycle after q_ack; req_message=64'h1234; grant_idx=2.
- Round-robin: req_request=4'hF held, each requester re-asserting after its ack → grant order 0,1,2,3,0; no requester is acked twice before all others.
- Abort: requester 1 drops its request 1 cycle after q_request rises; q_ack arrives 5 cycles later → q_request stays high until q_ack; req_ack stays 0; next IDLE search starts at index 2.
- Ack-cycle race: req_request[3] drops in the same cycle q_ack=1 → no req_ack; req_message keeps its previous value.
- Async reset during WAIT: assert rst with q_request=1 → q_request=0, busy=0, grant_idx=0 immediately, without waiting for a clock edge; after release, requests arbitrate from index 0.
- With MRR_LB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: never assert q_ack → q_request falls after 8 WAIT cycles; timeout_count=1; no req_ack; the next requester is granted.
